// File: rtl/div_unit_pkg.sv
// Shared constants for the iterative divider: data width, control polarities,
// FSM state encodings, iteration counter width and a conditional-negate helper.
package div_unit_pkg;

  localparam int RegDataWidth = 32;
  localparam logic RstEnable = 1'b1;
  localparam logic WriteEnable = 1'b1;

  localparam int DivCntW = $clog2(RegDataWidth);

  localparam logic [1:0] DivIdle   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;

  function automatic logic [RegDataWidth-1:0] cond_neg(input logic [RegDataWidth-1:0] v,
                                                       input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, try to
// subtract the divisor, keep the difference only when it does not go negative.
import div_unit_pkg::*;

module div_step #(
  parameter int DATA_W = RegDataWidth
) (
  input  logic [DATA_W-1:0] rem,
  input  logic              bit_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic              q_bit
);

  logic [DATA_W:0] trial;
  logic [DATA_W:0] diff;

  // rem < divisor, so trial fits in DATA_W+1 bits and diff's top bit is the borrow
  assign trial    = {rem, bit_in};
  assign diff     = trial - {1'b0, divisor};
  assign q_bit    = ~diff[DATA_W];
  assign rem_next = q_bit ? diff[DATA_W-1:0] : trial[DATA_W-1:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider feeding the hi/lo register file.
// Define DIV_SIGNED_EN to honour signed_div; otherwise every division is unsigned.
import div_unit_pkg::*;

// state      | meaning
// DivIdle    | waiting for start, results and strobes held at 0
// DivByZero  | divisor was 0, one cycle before reporting
// DivOn      | one restoring step per cycle, DATA_W cycles
// DivEnd     | one cycle of done / write enables with results
module div_unit #(
  parameter int DATA_W = RegDataWidth
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_div,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              cancel,
  output logic              busy,
  output logic              done,
  output logic              we_hi,
  output logic [DATA_W-1:0] hi_data_out,
  output logic              we_lo,
  output logic [DATA_W-1:0] lo_data_out,
  output logic              div_by_zero
);

  logic [1:0]         state;
  logic [DivCntW-1:0] cnt;
  logic [DATA_W-1:0]  dq;
  logic [DATA_W-1:0]  rem;
  logic [DATA_W-1:0]  dvs;
  logic               dz;
  logic [DATA_W-1:0]  dvd_mag;
  logic [DATA_W-1:0]  dvs_mag;
  logic [DATA_W-1:0]  rem_next;
  logic               q_bit;
  logic [DATA_W-1:0]  lo_res;
  logic [DATA_W-1:0]  hi_res;
  logic               valid;
  logic               accept;

  assign accept = (state == DivIdle) && start && !cancel;

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  assign dvd_mag = cond_neg(dividend, signed_div & dividend[DATA_W-1]);
  assign dvs_mag = cond_neg(divisor, signed_div & divisor[DATA_W-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= signed_div & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
      neg_r <= signed_div & dividend[DATA_W-1];
    end
  end

  assign lo_res = dz ? {DATA_W{1'b1}} : cond_neg(dq, neg_q);
  assign hi_res = dz ? dq : cond_neg(rem, neg_r);
`else
  logic unused_signed_div;

  assign unused_signed_div = signed_div;
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign lo_res  = dz ? {DATA_W{1'b1}} : dq;
  assign hi_res  = dz ? dq : rem;
`endif

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem      (rem),
    .bit_in   (dq[DATA_W-1]),
    .divisor  (dvs),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // dq starts as the dividend magnitude and fills with quotient bits from the right
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state <= DivIdle;
      cnt   <= '0;
      dq    <= '0;
      rem   <= '0;
      dvs   <= '0;
      dz    <= 1'b0;
    end else begin
      case (state)
        DivIdle: begin
          if (accept) begin
            cnt <= '0;
            rem <= '0;
            if (divisor == '0) begin
              state <= DivByZero;
              dq    <= dividend;
              dvs   <= '0;
              dz    <= 1'b1;
            end else begin
              state <= DivOn;
              dq    <= dvd_mag;
              dvs   <= dvs_mag;
              dz    <= 1'b0;
            end
          end
        end
        DivByZero: state <= cancel ? DivIdle : DivEnd;
        DivOn: begin
          if (cancel) begin
            state <= DivIdle;
          end else begin
            dq  <= {dq[DATA_W-2:0], q_bit};
            rem <= rem_next;
            cnt <= cnt + 1'b1;
            if (cnt == DivCntW'(DATA_W - 1)) state <= DivEnd;
          end
        end
        DivEnd:  state <= DivIdle;
        default: state <= DivIdle;
      endcase
    end
  end

  // a flush landing in the END cycle must kill that cycle's writes
  assign valid       = (state == DivEnd) && !cancel;
  assign busy        = (state != DivIdle);
  assign done        = valid;
  assign we_hi       = valid ? WriteEnable : ~WriteEnable;
  assign we_lo       = valid ? WriteEnable : ~WriteEnable;
  assign div_by_zero = valid & dz;
  assign lo_data_out = valid ? lo_res : '0;
  assign hi_data_out = valid ? hi_res : '0;

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter: DATA_W, default 32, operand/result width; SHALL equal `RegDataWidth.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high (`RstEnable); the block SHALL have exactly this one clock and this one reset.
REQ-004 start  in  1  request division; sampled only in IDLE.
REQ-005 signed_div  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
REQ-006 dividend  in  DATA_W  numerator; sampled with start.
REQ-007 divisor  in  DATA_W  denominator; sampled with start.
REQ-008 cancel  in  1  pipeline flush; aborts an operation in progress.
REQ-009 busy  out  1  stall request to pipeline; high whenever state != IDLE.
REQ-010 done  out  1  one-cycle pulse when results are valid.
REQ-011 we_hi  out  1  write enable to hi/lo register file hi port (`WriteEnable polarity).
REQ-012 hi_data_out  out  DATA_W  remainder.
REQ-013 we_lo  out  1  write enable to lo port.
REQ-014 lo_data_out  out  DATA_W  quotient.
REQ-015 div_by_zero  out  1  high together with done when divisor was 0.

Function
REQ-016 FSM states SHALL be IDLE, DIVZERO, ON, END.
REQ-017 IDLE & start & !cancel & divisor!=0 -> ON; operands latched that edge, iteration counter cleared.
REQ-018 IDLE & start & !cancel & divisor==0 -> DIVZERO; DIVZERO -> END next cycle.
REQ-019 ON SHALL perform one radix-2 restoring step per cycle for exactly DATA_W cycles, then -> END.
REQ-020 END SHALL last one cycle asserting done=we_hi=we_lo=1 and results, then -> IDLE.
REQ-021 Latency: start sampled at edge N; done high in cycle N+DATA_W+1 (33 for DATA_W=32); divide-by-zero done in cycle N+2.
REQ-022 Outside END, done, we_hi, we_lo, div_by_zero SHALL be 0 and hi/lo_data_out SHALL hold 0.
REQ-023 Divide-by-zero result: lo_data_out = all ones, hi_data_out = latched dividend, div_by_zero=1.
REQ-024 Signed: divide magnitudes; quotient negated when operand signs differ; remainder takes dividend sign (truncating division).
REQ-025 Signed most-negative / -1: quotient wraps to 0x80000000, remainder 0; no flag.
REQ-026 cancel in DIVZERO, ON or END -> IDLE next edge; no write enable asserted in any later cycle; cancel in END suppresses that cycle's writes combinationally.
REQ-027 start while not IDLE SHALL be ignored; start and cancel together in IDLE: cancel wins, stays IDLE.
REQ-028 Operand changes after the start edge SHALL NOT affect the result.

Reset
REQ-029 rst high SHALL immediately force IDLE, counter 0, all outputs 0, independent of clk, including mid-operation.
REQ-030 After rst release, first start SHALL be honoured on the next rising edge.

Configuration
REQ-031 Macro DIV_SIGNED_EN: defined -> signed_div honoured per REQ-024/025; undefined -> signed_div ignored, all divisions unsigned, sign-fixup logic absent.

Structure
REQ-032 State encodings (DivIdle, DivByZero, DivOn, DivEnd) and counter width SHALL live in the shared define.v.
REQ-033 One sub-module div_step: combinational single restoring step (partial remainder, divisor -> next remainder, quotient bit); div_unit owns FSM, counter, sign handling.

Verification
REQ-034 Unsigned 100/7 start at edge 0 -> busy cycles 1..33, done in cycle 33, lo=14, hi=2, we_hi=we_lo=1 only then.
REQ-035 Signed -7/2 (0xFFFFFFF9/0x2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; unsigned same operands -> lo=0x7FFFFFFC, hi=1 (with DIV_SIGNED_EN undefined, signed request gives the unsigned result).
REQ-036 5/0 -> done in cycle 2, lo=0xFFFFFFFF, hi=5, div_by_zero=1.
REQ-037 Signed 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
REQ-038 cancel in cycle 10 of 100/7 -> busy low cycle 11, no we pulse; new start 3/2 then gives lo=1, hi=1.
REQ-039 rst pulse between edges in cycle 15 -> outputs 0 and busy low immediately, no later write.
